// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer
// Avalon-MM initiator for a 1-bit edge-capture PIO. After reset it writes
// MASK_VAL to the PIO irq mask. Each irq is serviced by reading
// edge_capture, clearing it, then reading the live data register. The data
// value is handed downstream as a valid/ready event. A service that finds
// edge_capture == 0 bumps a saturating spurious counter instead.
// Optional feature macro: SVC_IRQ_SYNC_EN puts irq through a 2-flop
// synchronizer, which adds 2 cycles of irq-to-event latency.
// READ_LATENCY must lie in 1..4 because the wait counter is 2 bits wide.
module pio_irq_servicer #(
    parameter int DATA_W       = 1,
    parameter int READ_LATENCY = 1,
    parameter int MASK_VAL     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              irq,
    output logic [1:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [7:0]        spurious_cnt
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_CAP,
        S_WAIT_CAP,
        S_CLR,
        S_RD_DATA,
        S_WAIT_DAT,
        S_EMIT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;
    // The wait counter runs from READ_LATENCY-1 down to 0, so the sample
    // lands on the edge ending the READ_LATENCY-th cycle after the issue.
    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

    state_t            state, state_next;
    logic [1:0]        wait_cnt, wait_cnt_next;
    logic              irq_fsm;

    logic [1:0]        address_next;
    logic              chipselect_next;
    logic              write_n_next;
    logic [DATA_W-1:0] writedata_next;
    logic              evt_valid_next;
    logic [DATA_W-1:0] evt_data_next;
    logic [7:0]        spurious_next;

`ifdef SVC_IRQ_SYNC_EN
    logic [1:0] irq_sync;

    // Two-flop synchronizer that brings irq into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge value of its neighbours.
        if (!reset_n) begin
            irq_sync <= 2'b00;
        end else begin
            irq_sync <= {irq_sync[0], irq};
        end
    end

    assign irq_fsm = irq_sync[1];
`else
    assign irq_fsm = irq;
`endif

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_INIT;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state, datapath updates and bus decode of the state being entered.
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves it unassigned and no latch is inferred.
        state_next      = state;
        wait_cnt_next   = wait_cnt;
        evt_data_next   = evt_data;
        spurious_next   = spurious_cnt;
        address_next    = av_address;
        chipselect_next = 1'b0;
        write_n_next    = 1'b1;
        writedata_next  = '0;
        evt_valid_next  = 1'b0;

        case (state)
            // The chipselect register is still 0 in the partial cycle after
            // reset release; INIT is held until the mask write has been on
            // the bus for one full registered cycle.
            S_INIT: begin
                if (av_chipselect) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (irq_fsm) begin
                    state_next = S_RD_CAP;
                end
            end
            S_RD_CAP: begin
                state_next    = S_WAIT_CAP;
                wait_cnt_next = WAIT_LOAD;
            end
            S_WAIT_CAP: begin
                if (wait_cnt == 2'd0) begin
                    if (|av_readdata) begin
                        state_next = S_CLR;
                    end else begin
                        state_next = S_IDLE;
                        if (spurious_cnt != 8'hFF) begin
                            spurious_next = spurious_cnt + 8'd1;
                        end
                    end
                end else begin
                    wait_cnt_next = wait_cnt - 2'd1;
                end
            end
            S_CLR: begin
                state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                state_next    = S_WAIT_DAT;
                wait_cnt_next = WAIT_LOAD;
            end
            S_WAIT_DAT: begin
                if (wait_cnt == 2'd0) begin
                    evt_data_next = av_readdata;
                    state_next    = S_EMIT;
                end else begin
                    wait_cnt_next = wait_cnt - 2'd1;
                end
            end
            S_EMIT: begin
                if (evt_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_INIT;
            end
        endcase

        // Bus and event outputs describe the cycle spent in state_next; the
        // address is left untouched in wait states so it is held.
        case (state_next)
            S_INIT: begin
                address_next    = ADDR_MASK;
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                writedata_next  = DATA_W'(MASK_VAL);
            end
            S_RD_CAP: begin
                address_next    = ADDR_CAP;
                chipselect_next = 1'b1;
            end
            S_CLR: begin
                address_next    = ADDR_CAP;
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
            end
            S_RD_DATA: begin
                address_next    = ADDR_DATA;
                chipselect_next = 1'b1;
            end
            S_EMIT: begin
                evt_valid_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered bus, event and spurious-count outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_address    <= 2'd0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= '0;
            evt_valid     <= 1'b0;
            evt_data      <= '0;
            spurious_cnt  <= 8'd0;
        end else begin
            av_address    <= address_next;
            av_chipselect <= chipselect_next;
            av_write_n    <= write_n_next;
            av_writedata  <= writedata_next;
            evt_valid     <= evt_valid_next;
            evt_data      <= evt_data_next;
            spurious_cnt  <= spurious_next;
        end
    end

endmodule
